// File: rtl/top.sv
// Bit-serial accumulator processor: fetches 8-bit instructions MSB first on data,
// executes them against an accumulator, and streams the accumulator LSB first on OUT.
module top #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic data,
  output logic write,
  output logic result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    OUT
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] osr_q, osr_d;
  logic             write_q, write_d;
  logic             result_q, result_d;

  logic [WIDTH-1:0] imm;
  logic             lastBit;

  assign imm     = {{(WIDTH-4){1'b0}}, instr_q[3:0]};
  assign lastBit = (cnt_q == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      cnt_q    <= '0;
      sr_q     <= '0;
      instr_q  <= '0;
      acc_q    <= '0;
      osr_q    <= '0;
      write_q  <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      instr_q  <= instr_d;
      acc_q    <= acc_d;
      osr_q    <= osr_d;
      write_q  <= write_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    instr_d  = instr_q;
    acc_d    = acc_q;
    osr_d    = osr_q;
    write_d  = write_q;
    result_d = result_q;

    case (state_q)
      FETCH: begin
        sr_d  = {sr_q[WIDTH-3:0], data};
        cnt_d = cnt_q + CW'(1);
        if (lastBit) begin
          instr_d = {sr_q, data};
          cnt_d   = '0;
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = FETCH;
        // Opcodes 0x0 and 0xA-0xE fall through to the default and leave acc alone.
        case (instr_q[7:4])
          4'h1: acc_d = imm;
          4'h2: acc_d = acc_q + imm;
          4'h3: acc_d = acc_q - imm;
          4'h4: acc_d = acc_q & imm;
          4'h5: acc_d = acc_q | imm;
          4'h6: acc_d = acc_q ^ imm;
          4'h7: acc_d = {acc_q[WIDTH-2:0], 1'b0};
          4'h8: acc_d = {1'b0, acc_q[WIDTH-1:1]};
          4'h9: acc_d = ~acc_q;
          4'hF: begin
            osr_d    = acc_q;
            write_d  = 1'b1;
            result_d = acc_q[0];
            cnt_d    = '0;
            state_d  = OUT;
          end
          default: ;
        endcase
      end

      OUT: begin
        // result already shows osr_q[0]; the next bit up is presented each edge.
        cnt_d    = cnt_q + CW'(1);
        osr_d    = osr_q >> 1;
        result_d = osr_q[1];
        if (lastBit) begin
          write_d  = 1'b0;
          result_d = 1'b0;
          cnt_d    = '0;
          state_d  = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  assign write  = write_q;
  assign result = result_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: a table of instruction/expected-output records plus
// hand-written reset sequences mid-fetch and mid-output.
module tb_top;

  logic clk;
  logic rst;
  logic data;
  logic write;
  logic result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs[$];

  top #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .write  (write),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Shifts one instruction in; the data line keeps its last bit through EXEC/OUT.
  task automatic applyStimulus(input logic [7:0] instr, input logic [7:0] expOut);
    for (int i = 7; i >= 0; i--) begin
      data = instr[i];
      @(negedge clk);
    end
    checkOutput("writeDuringExec", {7'b0, write}, 8'h00);
    @(negedge clk);
    if (instr[7:4] == 4'hF) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("outWrite[%0d] instr %h", i, instr), {7'b0, write}, 8'h01);
        checkOutput($sformatf("outResult[%0d] instr %h", i, instr), {7'b0, result}, {7'b0, expOut[i]});
        @(negedge clk);
      end
    end
    checkOutput($sformatf("idleWrite instr %h", instr), {7'b0, write}, 8'h00);
    checkOutput($sformatf("idleResult instr %h", instr), {7'b0, result}, 8'h00);
  endtask

  task automatic applyReset();
    rst  = 1'b1;
    data = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("resetWrite", {7'b0, write}, 8'h00);
    checkOutput("resetResult", {7'b0, result}, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    data = 1'b1;

    // 0xFF on a reset accumulator, run twice with data held high
    vecs.push_back('{8'hFF, 8'h00});
    vecs.push_back('{8'hFF, 8'h00});
    // LDI 5, OUT
    vecs.push_back('{8'h15, 8'h00});
    vecs.push_back('{8'hF0, 8'h05});
    // 15 + 7 = 22
    vecs.push_back('{8'h1F, 8'h00});
    vecs.push_back('{8'h27, 8'h00});
    vecs.push_back('{8'hF0, 8'h16});
    // 0 - 1 wraps to 0xFF
    vecs.push_back('{8'h10, 8'h00});
    vecs.push_back('{8'h31, 8'h00});
    vecs.push_back('{8'hF0, 8'hFF});
    // 3 << 2 = 0x0C, NOT = 0xF3, XOR 0x0F = 0xFC
    vecs.push_back('{8'h13, 8'h00});
    vecs.push_back('{8'h70, 8'h00});
    vecs.push_back('{8'h70, 8'h00});
    vecs.push_back('{8'h9F, 8'h00});
    vecs.push_back('{8'h6F, 8'h00});
    vecs.push_back('{8'hF0, 8'hFC});
    // 0x0F +0xF = 0x1E, AND 0xC = 0x0C, OR 3 = 0x0F, SHR = 0x07, reserved and NOP keep it
    vecs.push_back('{8'h1F, 8'h00});
    vecs.push_back('{8'h2F, 8'h00});
    vecs.push_back('{8'h4C, 8'h00});
    vecs.push_back('{8'h53, 8'h00});
    vecs.push_back('{8'h80, 8'h00});
    vecs.push_back('{8'hA5, 8'h00});
    vecs.push_back('{8'hE3, 8'h00});
    vecs.push_back('{8'h00, 8'h00});
    vecs.push_back('{8'hF0, 8'h07});
    // SHL drops the MSB: 0x0F -> 1E -> 3C -> 78 -> F0 -> E0
    vecs.push_back('{8'h1F, 8'h00});
    for (int i = 0; i < 5; i++) vecs.push_back('{8'h70, 8'h00});
    vecs.push_back('{8'hF0, 8'hE0});
    // NOT E0 = 1F, NOT = E0, SHR fills MSB with 0 = 70
    vecs.push_back('{8'h9F, 8'h00});
    vecs.push_back('{8'h9F, 8'h00});
    vecs.push_back('{8'h80, 8'h00});
    vecs.push_back('{8'hF0, 8'h70});

    applyReset();

    // First OUT must raise write after exactly nine post-reset edges
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("latencyWrite edge %0d", i), {7'b0, write}, 8'h00);
      @(negedge clk);
    end
    checkOutput("latencyWriteHigh", {7'b0, write}, 8'h01);
    applyReset();

    foreach (vecs[i]) applyStimulus(vecs[i].instr, vecs[i].expOut);

    // Reset mid-fetch: abandon half an instruction, framing restarts at bit 7
    for (int i = 7; i >= 4; i--) begin
      data = 1'b1;
      @(negedge clk);
    end
    applyReset();
    applyStimulus(8'h15, 8'h00);

    // Reset during the 4th output bit of OUT on acc=5
    for (int i = 7; i >= 0; i--) begin
      data = (8'hF0 >> i) & 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("preResetResult[%0d]", i), {7'b0, result}, {7'b0, 8'h05 >> i} & 8'h01);
      @(negedge clk);
    end
    checkOutput("fourthBitWrite", {7'b0, write}, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midOutResetWrite", {7'b0, write}, 8'h00);
    checkOutput("midOutResetResult", {7'b0, result}, 8'h00);
    rst = 1'b0;
    applyStimulus(8'hF0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/top.md
Name: top

Overview:
- Minimal bit-serial accumulator processor, the top level of the microprocessor project.
- Instructions arrive one bit per clock on `data`. Each instruction is 8 bits.
- The processor executes each instruction against an 8-bit accumulator.
- On an OUT instruction it streams the accumulator serially on `result`, qualified by `write`.

Parameters:
- WIDTH, 8, accumulator and instruction width (fixed at 8; other values unsupported).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- data  input  1  serial instruction bit, sampled MSB first
- write  output  1  high while a valid result bit is on `result`
- result  output  1  serial accumulator bit, LSB first

Behaviour:
- Interface: one clock (`clk`); reset `rst` is synchronous and active-high.
- Reset:
  - state=FETCH, bit counter=0, shift register=0, acc=0x00.
  - `write`=0, `result`=0.
  - Reset applied in any state (mid-fetch, exec, output) aborts it. The next non-reset edge samples bit 7 of a new instruction.
- Outputs are registered, with no combinational path from `data`.
- States: FETCH, EXEC, OUT.
- FETCH:
  - Each edge: `sr <= {sr[6:0], data}`, `cnt <= cnt+1`.
  - On the edge where cnt==7: latch `instr = {sr[6:0], data}`, cnt<=0, go to EXEC.
  - Instruction framing is purely positional from reset; there is no start bit.
- EXEC: exactly one cycle; `data` is ignored. Decode opcode=instr[7:4], imm=instr[3:0], zero-extended to 8 bits:
  - 0x0 NOP
  - 0x1 LDI: acc=imm
  - 0x2 ADDI: acc=acc+imm mod 256
  - 0x3 SUBI: acc=acc-imm mod 256
  - 0x4 ANDI
  - 0x5 ORI
  - 0x6 XORI
  - 0x7 SHL: acc=acc<<1, LSB filled with 0
  - 0x8 SHR: acc=acc>>1, MSB filled with 0
  - 0x9 NOT: acc=~acc
  - 0xA–0xE: NOP (reserved)
  - 0xF OUT: acc unchanged; load output shift register with acc; `write<=1`, `result<=acc[0]`; go to OUT.
  - All other opcodes return to FETCH.
- OUT:
  - Lasts 8 cycles; `data` is ignored.
  - `write`=1 throughout; `result` presents acc[0]..acc[7], one bit per cycle.
  - On the edge ending the 8th bit: `write<=0`, `result<=0`, return to FETCH.
- Latency: instruction bits occupy cycles 0–7, EXEC is cycle 8, OUT bits occupy cycles 9–16. The next instruction's first bit is sampled in cycle 9 (non-OUT) or cycle 17 (OUT).
- Outside the OUT state, `write`=0 and `result`=0.
- Arithmetic wraps silently; there are no flags.

Test Plan:
- Hold `rst`=1 for 2 edges, then release with `data`=1 constant. Instruction 0xFF is OUT on acc=0x00. Expected: `write` rises after 9 post-reset edges, stays high 8 cycles with `result`=0 throughout, then instruction 0xFF repeats.
- Send 0x15 (LDI 5) then 0xF0 (OUT). Expected: `write` high 8 cycles; `result` = 1,0,1,0,0,0,0,0.
- Send 0x1F, 0x27, 0xF0. Expected: acc=0x16 (15+7=22); `result` = 0,1,1,0,1,0,0,0.
- Wrap-around: send 0x10, 0x31, 0xF0. Expected: acc=0xFF; `result` all ones for 8 cycles.
- Shift/logic: send 0x13, 0x70, 0x70, 0x9F, 0x6F, 0xF0. Expected: 3<<2=0x0C, NOT gives 0xF3, XOR 0x0F gives 0xFC; `result` = 0,0,1,1,1,1,1,1.
- Reset mid-OUT: assert `rst` during the 4th output bit. Expected: `write`=0 and `result`=0 the next cycle, acc=0. A following 0xF0 then outputs all zeros.
